// File: rtl/mux2_arbiter.sv
// Round-robin arbiter and sequencer for a shared 2:1 data mux.
// Grants one requester at a time, bounded by a hold limit, and registers the selected word.
module mux2_arbiter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {IDLE, G0, G1} state_t;

    localparam int unsigned CW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    // cnt saturates at the preemption point so a solo holder stays preemptible
    // once the other side starts waiting.
    localparam logic [CW-1:0] CNT_LIM = (MAX_HOLD == 0) ? '1 : CW'(MAX_HOLD - 1);

    state_t        state;
    state_t        nxt;
    logic [CW-1:0] cnt;
    logic          last;
    logic          hold_up;
    logic          xfer;

    assign hold_up = req0 && req1 && (MAX_HOLD != 0) && (cnt == CNT_LIM);
    assign xfer    = (gnt0 && req0) || (gnt1 && req1);

    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (req0 && req1) nxt = last ? G0 : G1;
                else if (req0)    nxt = G0;
                else if (req1)    nxt = G1;
            end
            G0: begin
                if (!req0)        nxt = req1 ? G1 : IDLE;
                else if (hold_up) nxt = G1;
            end
            G1: begin
                if (!req1)        nxt = req0 ? G0 : IDLE;
                else if (hold_up) nxt = G0;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            sel       <= 1'b0;
            last      <= 1'b1;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state <= nxt;
            gnt0  <= (nxt == G0);
            gnt1  <= (nxt == G1);
            if (nxt != state) begin
                cnt <= '0;
                if (nxt != IDLE) begin
                    last <= (nxt == G1);
                    sel  <= (nxt == G1);
                end
            end else if (state != IDLE && cnt != CNT_LIM) begin
                cnt <= cnt + CW'(1);
            end
            out_valid <= xfer;
            if (xfer) out_data <= sel ? in1 : in0;
        end
    end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Bench for mux2_arbiter: per-cycle comparison against a grant/turn model,
// plus literal expectations from the directed scenarios.
module tb_mux2_arbiter;

    localparam int MAXH = 4;

    logic       clk = 1'b0;
    logic       rst, req0, req1;
    logic [7:0] in0, in1;
    logic       gnt0, gnt1, sel, out_valid;
    logic [7:0] out_data;

    int vectors     = 0;
    int miscompares = 0;

    mux2_arbiter #(.WIDTH(8), .MAX_HOLD(MAXH)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .in0(in0), .in1(in1),
        .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .out_valid(out_valid), .out_data(out_data)
    );

    always #5 clk = ~clk;

    // Model: owner of the path (-1 none), grant cycles completed by the owner,
    // who was granted most recently, and what the output register must hold.
    int         m_owner = -1, m_held = 0, m_last = 1, m_new;
    logic       m_sel = 1'b0, m_ov = 1'b0;
    logic [7:0] m_od = '0;
    logic [1:0] m_req;
    logic [7:0] m_in [2];
    bit         m_ready = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1; m_held = 0; m_last = 1;
            m_sel = 1'b0; m_ov = 1'b0; m_od = '0;
            m_ready = 1;
        end else begin
            m_req = {req1, req0};
            m_in[0] = in0; m_in[1] = in1;
            m_ov = 1'b0;
            if (m_owner >= 0 && m_req[m_owner]) begin
                m_ov = 1'b1;
                m_od = m_in[m_owner];
            end
            if (m_owner < 0) begin
                if (m_req == 2'b11)    m_new = 1 - m_last;
                else if (m_req[0])     m_new = 0;
                else if (m_req[1])     m_new = 1;
                else                   m_new = -1;
            end else if (!m_req[m_owner]) begin
                m_new = m_req[1 - m_owner] ? 1 - m_owner : -1;
            end else if (m_req[1 - m_owner] && MAXH > 0 && m_held + 1 >= MAXH) begin
                m_new = 1 - m_owner;
            end else begin
                m_new = m_owner;
                m_held++;
            end
            if (m_new != m_owner) begin
                m_held = 0;
                if (m_new >= 0) begin
                    m_last = m_new;
                    m_sel  = (m_new == 1);
                end
            end
            m_owner = m_new;
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            vectors++;
            if (gnt0 !== (m_owner == 0) || gnt1 !== (m_owner == 1) || sel !== m_sel ||
                out_valid !== m_ov || out_data !== m_od) begin
                miscompares++;
                $display("FAIL model_cycle t=%0t got gnt=%b%b sel=%b ov=%b od=%h want gnt=%b%b sel=%b ov=%b od=%h",
                         $time, gnt0, gnt1, sel, out_valid, out_data,
                         (m_owner == 0), (m_owner == 1), m_sel, m_ov, m_od);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %0h want %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; in0 = '0; in1 = '0;
        cyc(); cyc();
        rst = 1'b0;
        repeat (5) begin
            cyc();
            chk("idle_gnt0", gnt0, 0); chk("idle_gnt1", gnt1, 0);
            chk("idle_sel", sel, 0);   chk("idle_ov", out_valid, 0);
            chk("idle_od", out_data, 0);
        end

        // single requester
        req0 = 1'b1; in0 = 8'hA5;
        cyc(); chk("single_gnt0", gnt0, 1); chk("single_ov_early", out_valid, 0);
        cyc(); chk("single_ov", out_valid, 1); chk("single_od", out_data, 8'hA5);
        chk("single_gnt1", gnt1, 0);
        cyc(); cyc();
        req0 = 1'b0;
        cyc(); chk("release_gnt0", gnt0, 0); chk("release_ov", out_valid, 0);

        // first tie after reset, then preemption every MAXH transfers
        rst = 1'b1; cyc(); rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1; in0 = 8'h11; in1 = 8'h22;
        cyc(); chk("tie_gnt0", gnt0, 1); chk("tie_gnt1", gnt1, 0); chk("tie_sel", sel, 0);
        for (int i = 0; i < 12; i++) begin
            cyc();
            chk("preempt_ov", out_valid, 1);
            chk("preempt_od", out_data, (i < 4 || i >= 8) ? 8'h11 : 8'h22);
            chk("preempt_sel", sel, ((i + 1) / 4) % 2);
        end

        // release handover from G0 straight to G1
        repeat (4) cyc();
        chk("handover_pre_gnt0", gnt0, 1);
        req0 = 1'b0;
        cyc(); chk("handover_gnt1", gnt1, 1); chk("handover_gap", out_valid, 0);
        cyc(); chk("handover_ov", out_valid, 1); chk("handover_od", out_data, 8'h22);

        // reset in the middle of a G1 stream
        in1 = 8'h3C;
        cyc(); chk("stream_od", out_data, 8'h3C);
        rst = 1'b1; req0 = 1'b1;
        cyc(); chk("midrst_gnt0", gnt0, 0); chk("midrst_gnt1", gnt1, 0);
        chk("midrst_ov", out_valid, 0); chk("midrst_od", out_data, 0);
        rst = 1'b0;
        cyc(); chk("postrst_gnt0", gnt0, 1);

        // randomized traffic with varying request density and rare resets
        for (int i = 0; i < 4000; i++) begin
            int dens;
            dens = (i / 500) % 4;
            rst  = ($urandom_range(0, 199) == 0);
            req0 = ($urandom_range(0, 3) < dens + 1);
            req1 = ($urandom_range(0, 3) < 4 - dens);
            in0  = 8'($urandom);
            in1  = 8'($urandom);
            cyc();
        end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (4) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
